// File: rtl/mul_div_iter_if.sv
// Request/response bundle between the EX-stage pipeline and the iterative
// multiply/divide unit. The pipeline drives through the master modport, the
// unit through the slave modport.
// Optional feature macro: MUL_DIV_MADD_EN (adds the hilo_i accumulator input).
interface mul_div_iter_if #(
    parameter int WIDTH = 32
);
    logic                 start_i;
    logic                 annul_i;
    logic [1:0]           op_i;
    logic                 signed_i;
    logic [WIDTH-1:0]     opa_i;
    logic [WIDTH-1:0]     opb_i;
`ifdef MUL_DIV_MADD_EN
    logic [2*WIDTH-1:0]   hilo_i;
`endif
    logic                 busy_o;
    logic                 ready_o;
    logic                 div_zero_o;
    logic [2*WIDTH-1:0]   result_o;

    modport master (
`ifdef MUL_DIV_MADD_EN
        output hilo_i,
`endif
        output start_i, annul_i, op_i, signed_i, opa_i, opb_i,
        input  busy_o, ready_o, div_zero_o, result_o
    );

    modport slave (
`ifdef MUL_DIV_MADD_EN
        input  hilo_i,
`endif
        input  start_i, annul_i, op_i, signed_i, opa_i, opb_i,
        output busy_o, ready_o, div_zero_o, result_o
    );
endinterface

// File: rtl/mul_div_iter.sv
// Iterative radix-2 multiply / restoring divide unit for the EX stage.
// Signed operands are converted to magnitudes at accept, the core iterates
// unsigned for WIDTH cycles, and the sign is restored in a single FIX cycle.
// Result layout: mul -> full product, div -> {remainder, quotient}.
// Optional feature macro: MUL_DIV_MADD_EN (op 11 = multiply then add hilo_i).
module mul_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst,
    mul_div_iter_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam int W2    = 2 * WIDTH;

    localparam logic [1:0] OP_MUL  = 2'b01;
    localparam logic [1:0] OP_DIV  = 2'b10;
    localparam logic [1:0] OP_MADD = 2'b11;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_next_s;

    logic [1:0]         op_r;
    logic               neg_a_r;
    logic               neg_b_r;
    logic               zero_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [W2-1:0]      a_r;        // mul: shifting multiplicand
    logic [WIDTH-1:0]   b_r;        // mul: shifting multiplier, div: divisor
    logic [W2-1:0]      acc_r;      // mul: product, div: {remainder, quotient}
`ifdef MUL_DIV_MADD_EN
    logic [W2-1:0]      hilo_r;
`endif
    logic               busy_r;
    logic               ready_r;
    logic               dz_r;
    logic [W2-1:0]      result_r;

    logic               op_legal_s;
    logic               accept_s;
    logic               div_zero_s;
    logic [WIDTH-1:0]   mag_a_s;
    logic [WIDTH-1:0]   mag_b_s;
    logic [W2-1:0]      mul_sum_s;
    logic [WIDTH+1:0]   div_diff_s;
    logic [W2-1:0]      fix_result_s;
    logic [WIDTH-1:0]   quo_s;
    logic [WIDTH-1:0]   rem_s;

    // Two's-complement magnitude of an operand when its sign is to be honoured.
    function automatic logic [WIDTH-1:0] mag_fn(input logic [WIDTH-1:0] v, input logic neg);
        mag_fn = neg ? (-v) : v;
    endfunction

    // Accept qualification and operand magnitude conversion.
    always_comb begin
        op_legal_s = 1'b0;
        case (bus.op_i)
            OP_MUL:  op_legal_s = 1'b1;
            OP_DIV:  op_legal_s = 1'b1;
`ifdef MUL_DIV_MADD_EN
            OP_MADD: op_legal_s = 1'b1;
`endif
            default: op_legal_s = 1'b0;
        endcase
        accept_s   = (state_r == S_IDLE) & bus.start_i & ~bus.annul_i & op_legal_s;
        div_zero_s = (bus.op_i == OP_DIV) & (bus.opb_i == '0);
        mag_a_s    = mag_fn(bus.opa_i, bus.signed_i & bus.opa_i[WIDTH-1]);
        mag_b_s    = mag_fn(bus.opb_i, bus.signed_i & bus.opb_i[WIDTH-1]);
    end

    // One iteration of shift-add multiply and restoring-divide trial subtract.
    always_comb begin
        mul_sum_s  = acc_r + a_r;
        // {remainder, next dividend bit} minus divisor; MSB set means borrow.
        div_diff_s = {1'b0, acc_r[W2-1:WIDTH-1]} - {2'b00, b_r};
    end

    // Sign correction (and optional accumulate) applied in the FIX cycle.
    always_comb begin
        quo_s        = acc_r[WIDTH-1:0];
        rem_s        = acc_r[W2-1:WIDTH];
        fix_result_s = '0;
        if (zero_r) begin
            fix_result_s = '0;
        end else if (op_r == OP_DIV) begin
            quo_s        = (neg_a_r ^ neg_b_r) ? (-acc_r[WIDTH-1:0]) : acc_r[WIDTH-1:0];
            rem_s        = neg_a_r ? (-acc_r[W2-1:WIDTH]) : acc_r[W2-1:WIDTH];
            fix_result_s = {rem_s, quo_s};
        end else begin
            fix_result_s = (neg_a_r ^ neg_b_r) ? (-acc_r) : acc_r;
`ifdef MUL_DIV_MADD_EN
            if (op_r == OP_MADD) begin
                fix_result_s = fix_result_s + hilo_r;
            end else begin
                fix_result_s = fix_result_s;
            end
`endif
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    state_next_s = div_zero_s ? S_FIX : S_BUSY;
                end else begin
                    state_next_s = S_IDLE;
                end
            end
            S_BUSY: begin
                if (bus.annul_i) begin
                    state_next_s = S_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    state_next_s = S_FIX;
                end else begin
                    state_next_s = S_BUSY;
                end
            end
            S_FIX: begin
                if (bus.annul_i) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            S_DONE: begin
                if (!bus.start_i) begin
                    state_next_s = S_IDLE;
                end else begin
                    state_next_s = S_DONE;
                end
            end
            default: state_next_s = S_IDLE;
        endcase
    end

    // Datapath: operand capture, iteration, result registration and outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_r     <= 2'b00;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            zero_r   <= 1'b0;
            cnt_r    <= '0;
            a_r      <= '0;
            b_r      <= '0;
            acc_r    <= '0;
`ifdef MUL_DIV_MADD_EN
            hilo_r   <= '0;
`endif
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            dz_r     <= 1'b0;
            result_r <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        op_r    <= bus.op_i;
                        neg_a_r <= bus.signed_i & bus.opa_i[WIDTH-1];
                        neg_b_r <= bus.signed_i & bus.opb_i[WIDTH-1];
                        zero_r  <= div_zero_s;
                        cnt_r   <= '0;
                        b_r     <= mag_b_s;
                        busy_r  <= 1'b1;
`ifdef MUL_DIV_MADD_EN
                        hilo_r  <= bus.hilo_i;
`endif
                        if (bus.op_i == OP_DIV) begin
                            a_r   <= '0;
                            acc_r <= {{WIDTH{1'b0}}, mag_a_s};
                        end else begin
                            a_r   <= {{WIDTH{1'b0}}, mag_a_s};
                            acc_r <= '0;
                        end
                    end
                end
                S_BUSY: begin
                    if (bus.annul_i) begin
                        busy_r <= 1'b0;
                    end else begin
                        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                        if (op_r == OP_DIV) begin
                            if (div_diff_s[WIDTH+1]) begin
                                acc_r <= {acc_r[W2-2:0], 1'b0};
                            end else begin
                                acc_r <= {div_diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
                            end
                        end else begin
                            if (b_r[0]) begin
                                acc_r <= mul_sum_s;
                            end
                            a_r <= {a_r[W2-2:0], 1'b0};
                            b_r <= {1'b0, b_r[WIDTH-1:1]};
                        end
                    end
                end
                S_FIX: begin
                    busy_r <= 1'b0;
                    if (!bus.annul_i) begin
                        ready_r  <= 1'b1;
                        dz_r     <= zero_r;
                        result_r <= fix_result_s;
                    end
                end
                S_DONE: begin
                    if (!bus.start_i) begin
                        ready_r  <= 1'b0;
                        dz_r     <= 1'b0;
                        result_r <= '0;
                    end
                end
                default: begin
                    busy_r   <= 1'b0;
                    ready_r  <= 1'b0;
                    dz_r     <= 1'b0;
                    result_r <= '0;
                end
            endcase
        end
    end

    assign bus.busy_o     = busy_r;
    assign bus.ready_o    = ready_r;
    assign bus.div_zero_o = dz_r;
    assign bus.result_o   = result_r;

endmodule
